// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that shares one sequential multiplier
// (run/ready/product handshake) between two requesters. It latches the
// winner's operands, pulses run, waits for ready with a timeout, and routes
// the product or an abort indication back to the winner.
`timescale 1ns/1ps

module mult_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic                 err0,
    output logic                 err1,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic [WIDTH-1:0]     mult_multiplicand,
    output logic [WIDTH-1:0]     mult_multiplier,
    output logic                 mult_run,
    output logic                 mult_reset,
    input  logic                 mult_ready,
    input  logic [2*WIDTH-1:0]   mult_product
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    // WAIT leaves on the cycle whose incremented count would reach TIMEOUT-1,
    // so the abort lands exactly TIMEOUT cycles after SETTLE.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_WAIT,
        S_DONE,
        S_RECOVER
    } state_t;

    state_t               state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 last_q,  last_d;
    logic [WIDTH-1:0]     opa_q,   opa_d;
    logic [WIDTH-1:0]     opb_q,   opb_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic                 pick;

    // Arbitration: sole requester wins; on a tie, the one that did not go last.
    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = ~last_q;
        end
    end

    // State, ownership, operand, result and timeout registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic for the arbitration / sequencing FSM.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick;
                    opa_d   = pick ? a1 : a0;
                    opb_d   = pick ? b1 : b0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // Ready is still stale here (the multiplier drops it after run).
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mult_ready) begin
                    result_d = mult_product;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    state_d  = S_RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            S_RECOVER: begin
                result_d = '0;
                last_d   = owner_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore-decoded pulses and status from registered state and owner.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        err0     = 1'b0;
        err1     = 1'b0;
        mult_run = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_ISSUE: begin
                gnt0     = ~owner_q;
                gnt1     = owner_q;
                mult_run = 1'b1;
            end
            S_DONE: begin
                done0 = ~owner_q;
                done1 = owner_q;
            end
            S_RECOVER: begin
                err0 = ~owner_q;
                err1 = owner_q;
            end
            default: begin
                gnt0 = 1'b0;
            end
        endcase
    end

    assign result            = result_q;
    assign mult_multiplicand = opa_q;
    assign mult_multiplier   = opb_q;
    assign mult_reset        = ~reset | (state_q == S_RECOVER);

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a small behavioural sequential multiplier.
`timescale 1ns/1ps

module tb_mult_arbiter;

    localparam int unsigned W   = 32;
    localparam int unsigned TO  = 128;
    localparam int unsigned LAT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0, req1;
    logic [W-1:0]    a0, b0, a1, b1;
    logic            gnt0, gnt1, done0, done1, err0, err1;
    logic [2*W-1:0]  result;
    logic            busy;
    logic [W-1:0]    mult_multiplicand, mult_multiplier;
    logic            mult_run, mult_reset, mult_ready;
    logic [2*W-1:0]  mult_product;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .result(result), .busy(busy),
        .mult_multiplicand(mult_multiplicand), .mult_multiplier(mult_multiplier),
        .mult_run(mult_run), .mult_reset(mult_reset),
        .mult_ready(mult_ready), .mult_product(mult_product)
    );

    // Behavioural multiplier: drops ready on run, raises it LAT cycles later.
    logic            m_ready;
    logic [2*W-1:0]  m_a, m_b, m_prod;
    int unsigned     m_cnt;
    logic            stub = 1'b0;

    always @(posedge clk or posedge mult_reset) begin
        if (mult_reset) begin
            m_ready <= 1'b1;
            m_cnt   <= 0;
            m_prod  <= '0;
        end else if (mult_run) begin
            m_ready <= 1'b0;
            m_cnt   <= LAT;
            m_a     <= {{W{1'b0}}, mult_multiplicand};
            m_b     <= {{W{1'b0}}, mult_multiplier};
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_ready <= 1'b1;
                m_prod  <= m_a * m_b;
            end
        end
    end

    assign mult_ready   = stub ? 1'b0 : m_ready;
    assign mult_product = m_prod;

    // Pulse tallies, sampled mid-cycle.
    int n_gnt0 = 0, n_gnt1 = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0;
    always @(negedge clk) begin
        if (gnt0)  n_gnt0++;
        if (gnt1)  n_gnt1++;
        if (done0) n_done0++;
        if (done1) n_done1++;
        if (err0)  n_err0++;
        if (err1)  n_err1++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic wait_gnt(output int who);
        int n;
        who = -1;
        n = 0;
        while (who < 0 && n < 50) begin
            tick();
            n++;
            if (gnt0) who = 0;
            else if (gnt1) who = 1;
        end
    endtask

    // kind: 0 = nothing within budget, 1 = done, 2 = err
    task automatic wait_end(output int kind, output int who);
        int n;
        kind = 0;
        who = -1;
        n = 0;
        while (kind == 0 && n < 300) begin
            tick();
            n++;
            if (done0)      begin kind = 1; who = 0; end
            else if (done1) begin kind = 1; who = 1; end
            else if (err0)  begin kind = 2; who = 0; end
            else if (err1)  begin kind = 2; who = 1; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        tick(); tick(); tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, mult_run, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 00000000",
                     {gnt0, gnt1, done0, done1, err0, err1, mult_run, busy});
        end
        checks++;
        if (result !== 64'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", result);
        end
        checks++;
        if ({mult_multiplicand, mult_multiplier} !== 64'h0) begin
            errors++;
            $display("FAIL reset_operands: got %h expected 0", {mult_multiplicand, mult_multiplier});
        end
        checks++;
        if (mult_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_mult_reset: got %b expected 1", mult_reset);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({mult_reset, busy} !== 2'b00) begin
            errors++;
            $display("FAIL release_idle: got mult_reset,busy=%b expected 00", {mult_reset, busy});
        end
    endtask

    task automatic test_single;
        int g0, g1, d1, kind, who;
        apply_reset();
        g0 = n_gnt0; g1 = n_gnt1; d1 = n_done1;
        a0 = 15; b0 = 19; req0 = 1'b1;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL single_gnt_latency: got gnt0,gnt1=%b expected 10", {gnt0, gnt1});
        end
        checks++;
        if ({mult_multiplicand, mult_multiplier} !== {32'd15, 32'd19}) begin
            errors++;
            $display("FAIL single_operands: got %h expected %h",
                     {mult_multiplicand, mult_multiplier}, {32'd15, 32'd19});
        end
        req0 = 1'b0;
        a0 = 99; b0 = 77;
        wait_end(kind, who);
        checks++;
        if (kind !== 1 || who !== 0 || result !== 64'd285) begin
            errors++;
            $display("FAIL single_done: got kind=%0d who=%0d result=%0d expected kind=1 who=0 result=285",
                     kind, who, result);
        end
        tick();
        checks++;
        if (n_gnt0 - g0 !== 1 || n_gnt1 - g1 !== 0 || n_done1 - d1 !== 0) begin
            errors++;
            $display("FAIL single_pulse_counts: got gnt0=%0d gnt1=%0d done1=%0d expected 1 0 0",
                     n_gnt0 - g0, n_gnt1 - g1, n_done1 - d1);
        end
    endtask

    task automatic test_both;
        int who, kind, dwho;
        apply_reset();
        a0 = 3; b0 = 4; a1 = 5; b1 = 6;
        req0 = 1'b1; req1 = 1'b1;
        wait_gnt(who);
        checks++;
        if (who !== 0) begin
            errors++;
            $display("FAIL both_first_gnt: got %0d expected 0", who);
        end
        req0 = 1'b0;
        wait_end(kind, dwho);
        checks++;
        if (kind !== 1 || dwho !== 0 || result !== 64'd12) begin
            errors++;
            $display("FAIL both_first_done: got kind=%0d who=%0d result=%0d expected 1 0 12",
                     kind, dwho, result);
        end
        wait_gnt(who);
        checks++;
        if (who !== 1) begin
            errors++;
            $display("FAIL both_second_gnt: got %0d expected 1", who);
        end
        req1 = 1'b0;
        wait_end(kind, dwho);
        checks++;
        if (kind !== 1 || dwho !== 1 || result !== 64'd30) begin
            errors++;
            $display("FAIL both_second_done: got kind=%0d who=%0d result=%0d expected 1 1 30",
                     kind, dwho, result);
        end
    endtask

    task automatic test_back_to_back;
        int who, kind, dwho;
        logic [63:0] expv [2];
        expv[0] = 64'd63;
        expv[1] = 64'd143;
        apply_reset();
        a0 = 7; b0 = 9; a1 = 11; b1 = 13;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(who);
            checks++;
            if (who !== i % 2) begin
                errors++;
                $display("FAIL fair_gnt[%0d]: got %0d expected %0d", i, who, i % 2);
            end
            wait_end(kind, dwho);
            checks++;
            if (kind !== 1 || dwho !== i % 2 || result !== expv[i % 2]) begin
                errors++;
                $display("FAIL fair_done[%0d]: got kind=%0d who=%0d result=%0d expected 1 %0d %0d",
                         i, kind, dwho, result, i % 2, expv[i % 2]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
    endtask

    task automatic test_max;
        int who, kind, dwho;
        a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; req0 = 1'b1;
        wait_gnt(who);
        req0 = 1'b0;
        wait_end(kind, dwho);
        checks++;
        if (kind !== 1 || dwho !== 0 || result !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL max_operands: got kind=%0d who=%0d result=%h expected 1 0 fffffffe00000001",
                     kind, dwho, result);
        end
        tick();
    endtask

    task automatic test_timeout;
        int who, err_at, d0, e1;
        logic rst_at, rst_before;
        logic [63:0] res_at;
        err_at = -1; rst_at = 1'b0; rst_before = 1'bx; res_at = '1;
        d0 = n_done0; e1 = n_err1;
        stub = 1'b1;
        a0 = 2; b0 = 3; req0 = 1'b1;
        wait_gnt(who);
        req0 = 1'b0;
        for (int n = 1; n <= int'(TO) + 3; n++) begin
            tick();
            if (n == int'(TO)) rst_before = mult_reset;
            if (err0 && err_at < 0) begin
                err_at = n;
                rst_at = mult_reset;
                res_at = result;
            end
        end
        checks++;
        if (err_at !== int'(TO) + 1) begin
            errors++;
            $display("FAIL timeout_err_cycle: got %0d cycles after gnt expected %0d", err_at, TO + 1);
        end
        checks++;
        if (rst_before !== 1'b0 || rst_at !== 1'b1) begin
            errors++;
            $display("FAIL timeout_mult_reset: got before=%b at_err=%b expected 0 1", rst_before, rst_at);
        end
        checks++;
        if (res_at !== 64'h0) begin
            errors++;
            $display("FAIL timeout_result: got %h expected 0", res_at);
        end
        checks++;
        if (busy !== 1'b0 || n_done0 - d0 !== 0 || n_err1 - e1 !== 0) begin
            errors++;
            $display("FAIL timeout_idle: got busy=%b done0=%0d err1=%0d expected 0 0 0",
                     busy, n_done0 - d0, n_err1 - e1);
        end
        stub = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int who, kind, dwho, p;
        a0 = 5; b0 = 5; req0 = 1'b1;
        wait_gnt(who);
        req0 = 1'b0;
        wait_end(kind, dwho);
        checks++;
        if (kind !== 1 || result !== 64'd25) begin
            errors++;
            $display("FAIL mid_pre_op: got kind=%0d result=%0d expected 1 25", kind, result);
        end
        a0 = 2; b0 = 3; req0 = 1'b1;
        wait_gnt(who);
        req0 = 1'b0;
        tick(); tick();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, err0, err1, mult_run, busy} !== 8'h00 || result !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got pulses=%b result=%h expected 00000000 0",
                     {gnt0, gnt1, done0, done1, err0, err1, mult_run, busy}, result);
        end
        checks++;
        if (mult_reset !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_mult_reset: got %b expected 1", mult_reset);
        end
        p = n_done0 + n_done1 + n_err0 + n_err1;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (n_done0 + n_done1 + n_err0 + n_err1 - p !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_pulse: got %0d pulses expected 0",
                     n_done0 + n_done1 + n_err0 + n_err1 - p);
        end
        a0 = 7; b0 = 8; req0 = 1'b1;
        wait_gnt(who);
        req0 = 1'b0;
        wait_end(kind, dwho);
        checks++;
        if (kind !== 1 || dwho !== 0 || result !== 64'd56) begin
            errors++;
            $display("FAIL mid_after_release: got kind=%0d who=%0d result=%0d expected 1 0 56",
                     kind, dwho, result);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_both();
        test_back_to_back();
        test_max();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
